modn_updown_counter: RTL and testbench
======================================

// Module: modn_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter with a built-in prescaler, parallel load,
//  wrap or saturate mode, and a cascadable carry/borrow pulse.
//  Generalises the fixed 2-bit free-running refresh counter: display digit scanning,
//  BCD digit chains in the calculator datapath, and timebase generation.
//  Stages cascade by wiring carry_out of stage i to en of stage i+1 (PRESCALE=1).
// PARAMETERS
//  WIDTH     4   count register width; requires MODULUS <= 2**WIDTH
//  MODULUS   10  count range 0..MODULUS-1; requires MODULUS >= 2
//  PRESCALE  1   one step every PRESCALE enabled cycles; 1 = step every enabled cycle
//  SATURATE  0   0: wrap at bounds; 1: hold at bounds
// PORTS
//  refresh_clock  in   1      sole clock; all state updates on its rising edge
//  reset          in   1      synchronous, active-high reset
//  en             in   1      count enable; advances the prescaler
//  up             in   1      direction: 1 = increment, 0 = decrement; sampled at the step edge
//  load           in   1      synchronous parallel load
//  load_value     in   WIDTH  value to load
//  count          out  WIDTH  current count (registered)
//  tick           out  1      1-cycle pulse in the cycle a new stepped count is shown
//  carry_out      out  1      1-cycle pulse on wrap (up 9->0 or down 0->9 for MODULUS=10)
//  at_max         out  1      count == MODULUS-1 (decoded from the register)
//  at_zero        out  1      count == 0 (decoded from the register)
// BEHAVIOUR
//  - Priority at each edge: reset > load > en step > hold.
//  - Reset: count=0, prescaler=0, tick=0, carry_out=0. Reset is sampled only at clock edges.
//  - Load: count <= load_value if load_value < MODULUS, else MODULUS-1 (clamped).
//    Load clears the prescaler and forces tick=0 and carry_out=0. Load overrides en in the same cycle.
//  - en=1: the prescaler increments. A step edge occurs when prescaler==PRESCALE-1;
//    on that edge the prescaler returns to 0.
//  - en=0: prescaler and count hold; tick=0 and carry_out=0. The prescaler phase is preserved
//    across en gaps.
//  - Step, up=1: count+1. At MODULUS-1, SATURATE=0 wraps to 0 and sets carry_out=1;
//    SATURATE=1 holds at MODULUS-1 with carry_out=0.
//  - Step, up=0: count-1. At 0, SATURATE=0 wraps to MODULUS-1 and sets carry_out=1;
//    SATURATE=1 holds at 0 with carry_out=0.
//  - Latency: count, tick and carry_out are registered together. Their new values are visible
//    in the cycle after the step edge. tick=1 on every step edge, including a saturated hold.
//  - up changing between step edges has no effect until the next step edge.
//  - Arithmetic is done at WIDTH bits. For MODULUS == 2**WIDTH, the wrap is the natural
//    overflow, and carry_out is still generated.
//  - at_max and at_zero are combinational from count only. They are valid from the first
//    cycle after reset (at_zero=1).
// STRUCTURE
//  - Shared package counter_pkg:
//    - DIR_UP=1'b1, DIR_DOWN=1'b0
//    - MODE_WRAP=0, MODE_SAT=1
//    - clog2 function, used to size the prescaler
//  - Sub-module tick_prescaler (PRESCALE, refresh_clock, reset, en, clear -> step):
//    - clog2(PRESCALE)-bit counter
//    - step is combinational from its register and en
//    - PRESCALE=1 degenerates to step=en
//  - Top level holds the count register, the bound/wrap logic and the output registers.
// TESTING
//  1. MODULUS=10, PRESCALE=1, en=1, up=1, 12 cycles after reset.
//     -> count 0..9,0,1; carry_out high only in the cycle count shows 0 after 9;
//        at_max high while count=9.
//  2. Load 0, then up=0 for 2 steps.
//     -> count 9 with carry_out=1, then 8 with carry_out=0; at_zero high only while count=0.
//  3. PRESCALE=4, en=1 for 8 cycles, then en=0 for 3 cycles, then en=1 for 4 cycles.
//     -> count 0->1->2->3; tick every 4th enabled cycle; prescaler phase kept across the gap.
//  4. load_value=13 -> count=9. load=1 together with en=1 at a step edge -> the load value wins,
//     tick=0.
//  5. SATURATE=1: up at 9 -> stays 9, carry_out=0, tick=1. Down at 0 -> stays 0, carry_out=0.
//  6. reset=1 for one edge while count=5, en=1.
//     -> next cycle count=0, tick=0, carry_out=0.
//     A reset pulse that falls between edges -> no effect.
//  Cascade: two instances, MODULUS=10 each, 100 steps -> tens digit increments on each
//  units carry; final value 00.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Direction and mode encodings are shared by every counter variant and its users.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE, producing a one-cycle step strobe.
// The phase register is held while en is low, so the cadence survives enable gaps.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic refresh_clock,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic step
);

    // Keep at least one bit so PRESCALE=1 still elaborates; the phase then stays at 0.
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign step = en && (phase_q == LAST_PHASE);

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge refresh_clock) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with prescaler, clamped parallel load, wrap/saturate
// bounds and a one-cycle carry pulse for cascading digit chains.
module modn_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             refresh_clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             carry_out,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load clamp.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam bit               SAT_MODE = (SATURATE != MODE_WRAP);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tick_q;
    logic             tick_d;
    logic             carry_q;
    logic             carry_d;
    logic             step;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        if ({1'b0, value} < MOD_EXT) begin
            return value;
        end
        return MAX_VAL;
    endfunction

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .refresh_clock(refresh_clock),
        .reset        (reset),
        .en           (en),
        .clear        (load),
        .step         (step)
    );

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (load) begin
            count_d = clamp_load(load_value);
        end else if (step) begin
            tick_d = 1'b1;
            if (up == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    if (!SAT_MODE) begin
                        count_d = '0;
                        carry_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    if (!SAT_MODE) begin
                        count_d = MAX_VAL;
                        carry_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge refresh_clock) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign carry_out = carry_q;
    assign at_max    = (count_q == MAX_VAL);
    assign at_zero   = (count_q == '0);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench for modn_updown_counter: wrap, saturate, prescaled,
// full-range and cascaded instances share one clock.
module tb_modn_updown_counter;

    typedef struct {
        int         cyc;
        int         which;
        logic [3:0] cnt;
        logic       tk;
        logic       cy;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset, en, up, load, c_en;
    logic [3:0] lv;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [3:0] a_cnt, p_cnt, s_cnt, m_cnt, c0_cnt, c1_cnt;
    logic a_tk, a_cy, a_mx, a_zr;
    logic p_tk, p_cy, p_mx, p_zr;
    logic s_tk, s_cy, s_mx, s_zr;
    logic m_tk, m_cy, m_mx, m_zr;
    logic c0_tk, c0_cy, c0_mx, c0_zr;
    logic c1_tk, c1_cy, c1_mx, c1_zr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modn_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .refresh_clock(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(a_cnt), .tick(a_tk), .carry_out(a_cy), .at_max(a_mx), .at_zero(a_zr));
    modn_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) u_p (
        .refresh_clock(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(p_cnt), .tick(p_tk), .carry_out(p_cy), .at_max(p_mx), .at_zero(p_zr));
    modn_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_s (
        .refresh_clock(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(s_cnt), .tick(s_tk), .carry_out(s_cy), .at_max(s_mx), .at_zero(s_zr));
    modn_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u_m (
        .refresh_clock(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(m_cnt), .tick(m_tk), .carry_out(m_cy), .at_max(m_mx), .at_zero(m_zr));
    modn_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_c0 (
        .refresh_clock(clk), .reset(reset), .en(c_en), .up(up), .load(load), .load_value(lv),
        .count(c0_cnt), .tick(c0_tk), .carry_out(c0_cy), .at_max(c0_mx), .at_zero(c0_zr));
    modn_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_c1 (
        .refresh_clock(clk), .reset(reset), .en(c0_cy), .up(up), .load(load), .load_value(lv),
        .count(c1_cnt), .tick(c1_tk), .carry_out(c1_cy), .at_max(c1_mx), .at_zero(c1_zr));

    // Expectation for the outputs visible after the next rising edge.
    task automatic push(input int which, input int cnt, input logic tk, input logic cy,
                        input string name);
        exp_t e;
        e.cyc   = cyc + 1;
        e.which = which;
        e.cnt   = 4'(cnt);
        e.tk    = tk;
        e.cy    = cy;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every due expectation on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            logic [7:0] act;
            logic [7:0] want;
            int         modv;
            mon_e = sb.pop_front();
            modv  = (mon_e.which == 3) ? 16 : 10;
            case (mon_e.which)
                0: act = {a_cnt, a_tk, a_cy, a_mx, a_zr};
                1: act = {p_cnt, p_tk, p_cy, p_mx, p_zr};
                2: act = {s_cnt, s_tk, s_cy, s_mx, s_zr};
                3: act = {m_cnt, m_tk, m_cy, m_mx, m_zr};
                4: act = {c0_cnt, c0_tk, c0_cy, c0_mx, c0_zr};
                default: act = {c1_cnt, c1_tk, c1_cy, c1_mx, c1_zr};
            endcase
            want = {mon_e.cnt, mon_e.tk, mon_e.cy,
                    (mon_e.cnt == 4'(modv - 1)), (mon_e.cnt == 4'd0)};
            total = total + 1;
            if (mon_e.cyc != cyc || act !== want) begin
                bad = bad + 1;
                $display("FAIL %s dut=%0d cyc=%0d due=%0d got cnt=%0d tick=%b carry=%b max=%b zero=%b want cnt=%0d tick=%b carry=%b max=%b zero=%b",
                         mon_e.name, mon_e.which, cyc, mon_e.cyc, act[7:4], act[3], act[2], act[1], act[0],
                         want[7:4], want[3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 4'd0; c_en = 1'b0;
        edge_();
        for (int w = 0; w < 6; w++) push(w, 0, 1'b0, 1'b0, "reset_state");
        edge_();
        reset = 1'b0;

        // Count up through the wrap; saturating instance sticks at 9.
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            push(0, i % 10, 1'b1, (i == 10), "up_count");
            push(2, (i < 9) ? i : 9, 1'b1, 1'b0, "sat_up");
            edge_();
        end

        // Load 0 then count down across the lower bound.
        load = 1'b1; lv = 4'd0;
        push(0, 0, 1'b0, 1'b0, "load0");
        push(2, 0, 1'b0, 1'b0, "sat_load0");
        edge_();
        load = 1'b0; up = 1'b0;
        push(0, 9, 1'b1, 1'b1, "down_wrap");
        push(2, 0, 1'b1, 1'b0, "sat_down");
        edge_();
        push(0, 8, 1'b1, 1'b0, "down_step");
        push(2, 0, 1'b1, 1'b0, "sat_down_hold");
        edge_();

        // Clamped load beats a simultaneous step; full-range instance overflows naturally.
        load = 1'b1; lv = 4'd13; up = 1'b1;
        push(0, 9, 1'b0, 1'b0, "load13_clamp");
        push(2, 9, 1'b0, 1'b0, "sat_load13");
        push(3, 13, 1'b0, 1'b0, "m_load13");
        edge_();
        lv = 4'd15;
        push(0, 9, 1'b0, 1'b0, "load15_clamp");
        push(3, 15, 1'b0, 1'b0, "m_load15");
        edge_();
        load = 1'b0;
        push(0, 0, 1'b1, 1'b1, "wrap_after_load");
        push(2, 9, 1'b1, 1'b0, "sat_up_at_max");
        push(3, 0, 1'b1, 1'b1, "m_overflow");
        edge_();
        up = 1'b0;
        push(0, 9, 1'b1, 1'b1, "down_wrap2");
        push(3, 15, 1'b1, 1'b1, "m_underflow");
        edge_();
        en = 1'b0;
        push(0, 9, 1'b0, 1'b0, "en_low_hold");
        edge_();

        // Prescale by 4 with an enable gap in mid-phase.
        reset = 1'b1;
        push(1, 0, 1'b0, 1'b0, "p_reset");
        edge_();
        reset = 1'b0; up = 1'b1; en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            push(1, k / 4, (k % 4 == 0), 1'b0, "prescale_a");
            edge_();
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(1, 1, 1'b0, 1'b0, "prescale_gap");
            edge_();
        end
        en = 1'b1;
        for (int k = 7; k <= 12; k++) begin
            push(1, k / 4, (k % 4 == 0), 1'b0, "prescale_b");
            edge_();
        end

        // Reset while counting, then a reset glitch between edges.
        reset = 1'b1;
        push(0, 0, 1'b0, 1'b0, "reset2");
        edge_();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push(0, k, 1'b1, 1'b0, "count_to5");
            edge_();
        end
        reset = 1'b1;
        push(0, 0, 1'b0, 1'b0, "reset_at5");
        edge_();
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            push(0, k, 1'b1, 1'b0, "post_reset");
            edge_();
        end
        en = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        push(0, 2, 1'b0, 1'b0, "reset_glitch");
        edge_();

        // Two-digit cascade, 100 unit steps.
        reset = 1'b1;
        push(4, 0, 1'b0, 1'b0, "cas_reset_u");
        push(5, 0, 1'b0, 1'b0, "cas_reset_t");
        edge_();
        reset = 1'b0; up = 1'b1; c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            push(4, k % 10, 1'b1, (k % 10 == 0), "cas_units");
            push(5, ((k - 1) / 10) % 10, (k >= 2 && (k - 1) % 10 == 0), 1'b0, "cas_tens");
            edge_();
        end
        c_en = 1'b0;
        push(4, 0, 1'b0, 1'b0, "cas_final_u");
        push(5, 0, 1'b1, 1'b1, "cas_final_t");
        edge_();

        edge_();
        edge_();
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
